odd_parity_serializer: RTL and testbench
========================================

// Module: odd_parity_serializer
// PURPOSE
//  Downstream stage of the odd parity generator: accepts a DATA_W-bit word over a valid/ready handshake,
//  computes its odd parity bit and shifts out a serial frame: start(0), data LSB-first, parity, stop(1).
//  Odd parity means the data bits plus the parity bit contain an odd number of ones.
//  The block feeds the board-level serial line. The receiving checker validates parity on that line.
// PARAMETERS
//  DATA_W        8   data bits per frame (>=1)
//  CLKS_PER_BIT  4   clk cycles each serial bit is held (>=1; 1 is legal)
//  STOP_BITS     1   number of stop bits (1 or 2)
// PORTS
//  clk         in   1       single clock; all state on rising edge
//  rst         in   1       synchronous, active-high reset
//  in_data     in   DATA_W  word to transmit; captured on handshake
//  in_valid    in   1       in_data valid
//  in_ready    out  1       block can accept a word (high only in IDLE)
//  tx          out  1       serial line, idles high
//  busy        out  1       frame in progress (any state other than IDLE)
//  frame_done  out  1       one-cycle pulse on the final cycle of the last stop bit
//  err_inject  in   1       only with OPS_ERR_INJECT_EN; see CONFIGURATION
// BEHAVIOUR
//  - Reset: state=IDLE, tx=1, busy=0, frame_done=0, in_ready=1 in the first cycle after rst deasserts.
//    The bit counter and cycle counter are cleared. rst mid-frame aborts the frame.
//    In the aborted case tx=1 on the next cycle and no frame_done pulse is produced.
//  - The handshake fires when in_valid && in_ready. On that edge the block:
//    - captures in_data into the shift register;
//    - sets the parity register to ~^in_data;
//    - enters START.
//    in_data changes after capture have no effect.
//  - in_ready = (state==IDLE), decoded from state only. It does not depend on in_valid.
//  - FSM: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
//    - Every state except IDLE lasts CLKS_PER_BIT cycles per bit.
//    - DATA lasts DATA_W bits; STOP lasts STOP_BITS bits.
//    - The cycle counter runs 0..CLKS_PER_BIT-1 and wraps on each bit boundary.
//    - The bit counter has width $clog2(DATA_W+1) and advances on each wrap.
//  - tx is registered and valid from the first cycle of each state. tx values per state:
//    START=0, DATA=shift_reg[0] (shifts right at each bit boundary), PARITY=parity register, STOP=1, IDLE=1.
//  - Latency: tx falls 1 cycle after the handshake edge.
//    Frame length is (2+DATA_W+STOP_BITS)*CLKS_PER_BIT cycles. The FSM returns to IDLE on the cycle after frame_done.
//  - Back-to-back: at least one IDLE cycle, with tx=1, separates frames. A word held valid is accepted in that IDLE cycle.
//  - in_valid while busy: ignored and not dropped. The word is accepted later because in_ready=0.
// CONFIGURATION
//  - Macro OPS_ERR_INJECT_EN defined:
//    - the err_inject port exists;
//    - if err_inject=1 on the handshake cycle, the captured parity bit is inverted (a deliberately bad frame);
//    - the setting is sampled only at the handshake and has no effect in the other states.
//  - Undefined: the port is absent and parity is always correct.
// STRUCTURE
//  - Shared header opg_pkg.vh, included by the RTL and the bench. It holds:
//    - localparams for the state encoding: S_IDLE, S_START, S_DATA, S_PARITY, S_STOP (3-bit);
//    - the TX_IDLE_LVL=1 constant;
//    - a function odd_par(data) returning ~^data.
//  - One sub-module, ops_bit_timer:
//    - CLKS_PER_BIT cycle counter with a clear input;
//    - output bit_end, high on count==CLKS_PER_BIT-1.
//  - The FSM, shift register and bit counter stay in the top module.
// TESTING (DATA_W=8, CLKS_PER_BIT=4, STOP_BITS=1; frame = 44 cycles)
//  1. Reset, then idle -> tx=1, busy=0, in_ready=1, frame_done=0 held for 20 cycles.
//  2. Send 8'b11101010 (5 ones) -> tx: 0 | 0,1,0,1,0,1,1,1 | parity 0 | stop 1.
//     Each bit is held 4 cycles. frame_done pulses on cycle 44 after the handshake.
//  3. Send 8'b10101010 and then 8'h00 with in_valid held high.
//     -> parity bits are 1 and 1, exactly one IDLE cycle separates the frames, and in_ready=0 throughout each frame.
//  4. Assert rst at cycle 20 of a frame carrying 8'b11111110 -> tx=1 on the next cycle, no frame_done pulse.
//     After rst, 8'b00101010 is sent with parity 0.
//  5. in_data changed to 8'hFF mid-frame after 8'b10001010 was accepted -> the serialized bits still equal 8'b10001010, parity 0.
//  6. OPS_ERR_INJECT_EN defined and err_inject=1 with 8'b10101000 (3 ones) -> parity slot is 1 instead of 0, and the next frame is correct.
//     The bench's line monitor checks the odd-parity property on every frame and flags the injected frame.

Source files
------------

// File: rtl/opg_pkg.sv
// Shared definitions for the odd parity serializer: FSM state encoding,
// serial line idle level and the odd parity helper.
package opg_pkg;

  // Serializer FSM states, 3-bit encoding.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  // Level driven on the serial line between frames and during stop bits.
  localparam logic TX_IDLE_LVL = 1'b1;

  // Widest word the parity helper accepts; narrower words are zero-extended,
  // which does not change the XOR reduction.
  localparam int unsigned ODD_PAR_MAX_W = 64;

  // Parity bit that makes data plus parity contain an odd number of ones.
  function automatic logic odd_par(input logic [ODD_PAR_MAX_W-1:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/odd_parity_serializer_bit_timer.sv
// ops_bit_timer: counts clk cycles within one serial bit. Held at zero while
// clr is high, wraps at CLKS_PER_BIT-1. bit_end flags the last cycle of the
// current bit; bit_end_next flags that the following cycle will be a last cycle.
module ops_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end,
  output logic bit_end_next
);

  localparam int unsigned CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: zero while cleared, wrap on the bit boundary, else increment.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {CW{1'b0}};
    end else if (count_q == LAST) begin
      count_d = {CW{1'b0}};
    end else begin
      count_d = count_q + CW'(1);
    end
  end

  // Cycle counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign bit_end      = (count_q == LAST);
  assign bit_end_next = (count_d == LAST);

endmodule

// File: rtl/odd_parity_serializer.sv
// odd_parity_serializer: takes a word over valid/ready and shifts out
// start(0), data LSB-first, odd parity, stop(1) on tx.
// Optional feature macro: OPS_ERR_INJECT_EN adds the err_inject port, which
// inverts the captured parity bit when high on the handshake cycle.
module odd_parity_serializer
  import opg_pkg::*;
#(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
`ifdef OPS_ERR_INJECT_EN
  ,
  input  logic              err_inject
`endif
);

  localparam int unsigned BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              parity_q, parity_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              tx_q, tx_d;
  logic              frame_done_q, frame_done_d;
  logic              accept_s;
  logic              inj_s;
  logic              bit_end_s;
  logic              bit_end_next_s;

`ifdef OPS_ERR_INJECT_EN
  assign inj_s = err_inject;
`else
  assign inj_s = 1'b0;
`endif

  assign accept_s = in_valid && (state_q == S_IDLE);

  ops_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk         (clk),
    .rst         (rst),
    .clr         (state_q == S_IDLE),
    .bit_end     (bit_end_s),
    .bit_end_next(bit_end_next_s)
  );

  // Next-state, shift, parity, bit count and the tx level of the next cycle.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    case (state_q)
      S_IDLE: begin
        tx_d = TX_IDLE_LVL;
        if (accept_s) begin
          shift_d   = in_data;
          parity_d  = odd_par(ODD_PAR_MAX_W'(in_data)) ^ inj_s;
          bit_cnt_d = {BW{1'b0}};
          state_d   = S_START;
          tx_d      = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          state_d   = S_DATA;
          bit_cnt_d = {BW{1'b0}};
          tx_d      = shift_q[0];
        end else begin
          tx_d = 1'b0;
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          if (bit_cnt_q == LAST_DATA) begin
            state_d   = S_PARITY;
            bit_cnt_d = {BW{1'b0}};
            tx_d      = parity_q;
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + BW'(1);
            tx_d      = shift_d[0];
          end
        end else begin
          tx_d = shift_q[0];
        end
      end
      S_PARITY: begin
        if (bit_end_s) begin
          state_d   = S_STOP;
          bit_cnt_d = {BW{1'b0}};
          tx_d      = TX_IDLE_LVL;
        end else begin
          tx_d = parity_q;
        end
      end
      S_STOP: begin
        tx_d = TX_IDLE_LVL;
        if (bit_end_s) begin
          if (bit_cnt_q == LAST_STOP) begin
            state_d   = S_IDLE;
            bit_cnt_d = {BW{1'b0}};
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end
      default: begin
        state_d   = S_IDLE;
        bit_cnt_d = {BW{1'b0}};
        tx_d      = TX_IDLE_LVL;
      end
    endcase
    // Registered pulse: high when the coming cycle is the last one of the last stop bit.
    frame_done_d = (state_d == S_STOP) && (bit_cnt_d == LAST_STOP) && bit_end_next_s;
  end

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      shift_q      <= {DATA_W{1'b0}};
      parity_q     <= 1'b0;
      bit_cnt_q    <= {BW{1'b0}};
      tx_q         <= TX_IDLE_LVL;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_q         <= tx_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign tx         = tx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_odd_parity_serializer.sv
// Scoreboard bench for odd_parity_serializer (DATA_W=8, CLKS_PER_BIT=4,
// STOP_BITS=1). Stimulus pushes hand-computed frames; a line monitor
// reassembles each frame from tx and compares.
module tb_odd_parity_serializer;
  import opg_pkg::*;

  localparam int DATA_W     = 8;
  localparam int CPB        = 4;
  localparam int STOP_BITS  = 1;
  localparam int FRAME_BITS = 2 + DATA_W + STOP_BITS;
  localparam int FRAME_CYC  = FRAME_BITS * CPB;

  typedef struct {
    logic [FRAME_BITS-1:0] bits;
    bit                    bad;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready, tx, busy, frame_done;
`ifdef OPS_ERR_INJECT_EN
  logic              err_inject_s = 1'b0;
`endif

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_frames = 0;
  int   last_gap = -1;

  always #5 clk = ~clk;

  odd_parity_serializer #(
    .DATA_W(DATA_W), .CLKS_PER_BIT(CPB), .STOP_BITS(STOP_BITS)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .busy(busy), .frame_done(frame_done)
`ifdef OPS_ERR_INJECT_EN
    , .err_inject(err_inject_s)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Offer a word; waits (bounded) for in_ready, handshake happens on the next posedge.
  task automatic send(input logic [7:0] data, input logic par, input bit bad,
                      input bit inj, input bit hold, input bit push);
    int t;
    exp_t e;
    @(negedge clk);
    in_data  = data;
    in_valid = 1'b1;
`ifdef OPS_ERR_INJECT_EN
    err_inject_s = inj;
`endif
    t = 0;
    while (!in_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("handshake_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    if (push) begin
      e.bits = {1'b1, par, data, 1'b0};
      e.bad  = bad;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
`ifdef OPS_ERR_INJECT_EN
    err_inject_s = 1'b0;
`endif
  endtask

  task automatic wait_frames(input int target);
    int t;
    t = 0;
    while (n_frames < target && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (n_frames < target) check("frame_timeout", 32'(n_frames), 32'(target));
  endtask

  // Line monitor: reassembles each frame from tx and checks it against the scoreboard.
  initial begin : monitor
    logic [FRAME_BITS-1:0] got;
    bit   prev, aborted, hold_ok, done_ok, ready_ok;
    int   gap_cnt;
    exp_t e;
    prev = 1'b0;
    gap_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
        continue;
      end
      if (busy && !prev) begin
        last_gap = gap_cnt;
        aborted = 1'b0; hold_ok = 1'b1; done_ok = 1'b1; ready_ok = 1'b1;
        got = '0;
        for (int k = 0; k < FRAME_CYC; k++) begin
          if (k > 0) @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          if (k % CPB == 0) got[k / CPB] = tx;
          else if (tx !== got[k / CPB]) hold_ok = 1'b0;
          if (frame_done !== (k == FRAME_CYC - 1)) done_ok = 1'b0;
          if (in_ready !== 1'b0 || busy !== 1'b1) ready_ok = 1'b0;
        end
        if (aborted) begin
          prev = 1'b0;
          gap_cnt = 0;
          continue;
        end
        check("bit_hold", 32'(hold_ok), 32'd1);
        check("frame_done_pos", 32'(done_ok), 32'd1);
        check("in_ready_low_in_frame", 32'(ready_ok), 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'(got), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("frame_bits", 32'(got), 32'(e.bits));
          check("odd_parity_prop", 32'(^got[FRAME_BITS-2:1]), e.bad ? 32'd0 : 32'd1);
        end
        @(negedge clk);
        check("post_frame_idle", {30'd0, busy, tx}, {30'd0, 1'b0, TX_IDLE_LVL});
        n_frames++;
        gap_cnt = 1;
        prev = busy;
      end else begin
        if (!busy) gap_cnt++;
        prev = busy;
      end
    end
  end

  // Directed stimulus.
  initial begin : stim
    logic fd_seen;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("reset_idle", {28'd0, tx, busy, in_ready, frame_done},
            {28'd0, TX_IDLE_LVL, 1'b0, 1'b1, 1'b0});
    end

    // 2: 11101010, five ones -> parity 0
    send(8'b11101010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_frames(1);

    // 3: back-to-back with in_valid held high
    send(8'b10101010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    send(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_frames(3);
    check("b2b_idle_gap", 32'(last_gap), 32'd1);

    // 4: reset on cycle 20 of a frame aborts it
    send(8'b11111110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_tx_high", {29'd0, tx, busy, in_ready}, {29'd0, TX_IDLE_LVL, 1'b0, 1'b1});
    fd_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (frame_done !== 1'b0) fd_seen = 1'b1;
    end
    check("abort_no_frame_done", 32'(fd_seen), 32'd0);
    send(8'b00101010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_frames(4);

    // 5: in_data changes after capture
    send(8'b10001010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    in_data = 8'hFF;
    wait_frames(5);

`ifdef OPS_ERR_INJECT_EN
    // 6: injected parity error, then a clean frame with err_inject toggled mid-frame
    send(8'b10101000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    send(8'b10101000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    err_inject_s = 1'b1;
    repeat (4) @(negedge clk);
    err_inject_s = 1'b0;
    wait_frames(7);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
